// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, RCON table, byte/word/block types,
// FSM encoding and the GF(2^8) / key-expansion helpers used by the
// iterative encryption datapath.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } fsm_t;

  // Round constants RCON[1..10]; any other index yields zero.
  function automatic byte_t rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t acc;
    byte_t x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Byte 0 sits in bits [7:0]; RotWord shifts every byte down one slot and
  // wraps byte 0 into byte 3.
  function automatic word_t rot_word(input word_t w);
    return {w[7:0], w[31:8]};
  endfunction

  // One AES-128 key-schedule step. The caller supplies SubWord(RotWord(w3))
  // so the S-box hardware can live in separate instances.
  function automatic block_t next_key(input block_t rk, input word_t sub,
                                      input byte_t rc);
    word_t t;
    word_t n0;
    word_t n1;
    word_t n2;
    word_t n3;
    t  = sub ^ {24'h0, rc};
    n0 = rk[31:0]   ^ t;
    n1 = rk[63:32]  ^ n0;
    n2 = rk[95:64]  ^ n1;
    n3 = rk[127:96] ^ n2;
    return {n3, n2, n1, n0};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Computed rather than tabulated so the same block serves
// both the key schedule and the SubBytes stage.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub
);

  byte_t pw;
  byte_t inv;

  // Inverse as data^254 = product of data^(2^k), k=1..7; affine map on top.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    pw  = data;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    sub = inv
        ^ {inv[6:0], inv[7]}
        ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]}
        ^ 8'h63;
  end

endmodule

// File: rtl/addroundkey_keysched.sv
// Registered AddRoundKey stage with an on-the-fly AES-128 key schedule.
// Each accepted beat is XORed with the current round key and registered,
// then the key advances for the next round. mc_bypass tells the upstream
// MixColumns stage to pass data through on the final round.
module addroundkey_keysched
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         mc_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [3:0]   out_round,
  output logic         out_last,
  output logic         busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  fsm_t       state;
  logic [3:0] round;
  block_t     rk;
  word_t      rot;
  word_t      sub_word;
  block_t     rk_next;
  logic       accept;

  assign rot = rot_word(rk[127:96]);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .data (rot[8*g +: 8]),
      .sub  (sub_word[8*g +: 8])
    );
  end

  assign rk_next = next_key(rk, sub_word, rcon(round + 4'd1));

  // Start takes priority over any beat offered in the same cycle, and a held
  // result must be consumed before a new one may overwrite it.
  assign in_ready  = (state == ACTIVE) && !start && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mc_bypass = (state == ACTIVE) && (round == LAST_ROUND);
  assign busy      = (state == ACTIVE);

  // FSM, round counter, round key and output register in one sequential block.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!rst_n) begin
      state     <= IDLE;
      round     <= 4'd0;
      rk        <= '0;
      out_state <= '0;
      out_round <= 4'd0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (start) begin
      state     <= ACTIVE;
      round     <= 4'd0;
      rk        <= key_in;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_state <= in_state ^ rk;
      out_round <= round;
      out_last  <= (round == LAST_ROUND);
      out_valid <= 1'b1;
      if (round == LAST_ROUND) begin
        state <= IDLE;
      end else begin
        rk    <= rk_next;
        round <= round + 4'd1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addroundkey_keysched.sv
// Scoreboard bench for addroundkey_keysched: the driver pushes the expected
// result of every accepted beat; an independent monitor pops and compares
// each result the DUT hands downstream. Vectors are FIPS-197 values written
// byte 0 first and swapped onto the bus layout (byte i at [8i+7:8i]).
module tb_addroundkey_keysched;

  typedef struct {
    logic [127:0] st;
    logic [3:0]   rnd;
    logic         lst;
    bit           chk;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         mc_bypass;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_state;
  logic [3:0]   out_round;
  logic         out_last;
  logic         busy;

  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [7:0]   sbox_tab [0:255];
  logic [127:0] rk_tab   [0:10];
  logic [127:0] key_a;
  logic [127:0] cur;
  logic [127:0] nxt;

  addroundkey_keysched #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .mc_bypass (mc_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .out_round (out_round),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Convert a byte-0-first hex constant to the bus layout.
  function automatic logic [127:0] fb(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Build the S-box from exp/log tables over generator 3.
  task automatic build_sbox();
    int lg [0:255];
    logic [7:0] ex [0:255];
    logic [7:0] v;
    logic [7:0] b;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = v;
      lg[v] = i;
      v = v ^ xt(v);
    end
    for (int x = 0; x < 256; x++) begin
      b = (x == 0) ? 8'h00 : ex[(255 - lg[x]) % 255];
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
      sbox_tab[x] = s;
    end
  endtask

  // Reference SubBytes + ShiftRows (state byte index = row + 4*col).
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        r[8*(w+4*c) +: 8] = sbox_tab[s[8*(w+4*((c+w)%4)) +: 8]];
    return r;
  endfunction

  // Reference MixColumns (plays the upstream mixcolumns stage).
  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(4*c)   +: 8];
      a1 = s[8*(4*c+1) +: 8];
      a2 = s[8*(4*c+2) +: 8];
      a3 = s[8*(4*c+3) +: 8];
      r[8*(4*c)   +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[8*(4*c+1) +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[8*(4*c+2) +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[8*(4*c+3) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse start for one cycle; called just after a rising edge.
  task automatic do_start(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    check("in_ready_during_start", in_ready, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  // Offer one beat, push its expectation on the accepting cycle and return
  // just after the accepting edge.
  task automatic send_beat(input logic [127:0] st, input logic [127:0] exp,
                           input int rnd, input bit chk);
    int n;
    in_state = st;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL beat_timeout: round %0d never accepted, in_ready=%0b", rnd, in_ready);
      in_valid = 1'b0;
      return;
    end
    sb.push_back('{st: exp, rnd: 4'(rnd), lst: (rnd == 10), chk: chk});
    check("mc_bypass", mc_bypass, (rnd == 10));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare each result as it is handed downstream.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got round %0d, expected no output", out_round);
      end else begin
        mon_e = sb.pop_front();
        check("out_round", out_round, mon_e.rnd);
        check("out_last", out_last, mon_e.lst);
        if (mon_e.chk) check("out_state", out_state, mon_e.st);
      end
    end
  end

  initial begin
    build_sbox();
    key_a     = fb(128'h2b7e151628aed2a6abf7158809cf4f3c);
    rk_tab[0] = key_a;
    rk_tab[1] = fb(128'ha0fafe1788542cb123a339392a6c7605);
    rk_tab[2] = fb(128'hf2c295f27a96b9435935807a7359f67f);
    rk_tab[3] = fb(128'h3d80477d4716fe3e1e237e446d7a883b);
    rk_tab[4] = fb(128'hef44a541a8525b7fb671253bdb0bad00);
    rk_tab[5] = fb(128'hd4d1c6f87c839d87caf2b8bc11f915bc);
    rk_tab[6] = fb(128'h6d88a37a110b3efddbf98641ca0093fd);
    rk_tab[7] = fb(128'h4e54f70e5f5fc9f384a64fb24ea6dc4f);
    rk_tab[8] = fb(128'head27321b58dbad2312bf5607f8d292f);
    rk_tab[9] = fb(128'hac7766f319fadc2128d12941575c006e);
    rk_tab[10] = fb(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_state", out_state, 0);
    check("rst_out_round", out_round, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_mc_bypass", mc_bypass, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // IDLE ignores offered beats.
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // Key schedule: all-zero state exposes every round key, back to back.
    do_start(key_a);
    for (int r = 0; r <= 10; r++) send_beat('0, rk_tab[r], r, 1'b1);
    check("busy_after_final", busy, 0);
    check("mc_bypass_after_final", mc_bypass, 0);

    // Full encryption loop with reference SubBytes/ShiftRows/MixColumns.
    do_start(key_a);
    send_beat(fb(128'h3243f6a8885a308d313198a2e0370734),
              fb(128'h193de3bea0f4e22b9ac68d2ae9f84808), 0, 1'b1);
    cur = out_state;
    for (int r = 1; r <= 10; r++) begin
      nxt = sub_shift(cur);
      if (r < 10) nxt = mix(nxt);
      send_beat(nxt, (r == 10) ? fb(128'h3925841d02dc09fbdc118597196a0b32) : '0,
                r, (r == 10));
      cur = out_state;
    end

    // Back-pressure at round 4.
    do_start(key_a);
    for (int r = 0; r <= 4; r++) send_beat('0, rk_tab[r], r, 1'b1);
    out_ready = 1'b0;
    in_state  = '0;
    in_valid  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_out_state", out_state, rk_tab[4]);
      check("bp_out_round", out_round, 4);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int r = 5; r <= 10; r++) send_beat('0, rk_tab[r], r, 1'b1);

    // Restart at round 6 with an all-zero key while a beat is offered.
    do_start(key_a);
    for (int r = 0; r <= 5; r++) send_beat('0, rk_tab[r], r, 1'b1);
    start    = 1'b1;
    key_in   = '0;
    in_state = '0;
    in_valid = 1'b1;
    @(negedge clk);
    check("restart_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    check("restart_out_valid", out_valid, 0);
    check("restart_busy", busy, 1);
    send_beat('0, '0, 0, 1'b1);
    send_beat('0, fb(128'h62636363626363636263636362636363), 1, 1'b1);

    // Asynchronous reset with a held result.
    do_start(key_a);
    for (int r = 0; r <= 2; r++) send_beat('0, rk_tab[r], r, 1'b1);
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_state", out_state, 0);
    check("arst_out_round", out_round, 0);
    check("arst_busy", busy, 0);
    check("arst_mc_bypass", mc_bypass, 0);
    check("arst_in_ready", in_ready, 0);
    sb.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 0);
      check("post_rst_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addroundkey_keysched.md
# addroundkey_keysched

Registered AddRoundKey stage with an on-the-fly AES-128 key schedule. It consumes the 128-bit state from `mixcolumns`, XORs it with the current round key and registers the result. It then advances the round key for the next beat. It also drives `mc_bypass` back to `mixcolumns` so that MixColumns is skipped on the final round. It sits directly downstream of `mixcolumns` in the iterative encryption datapath.

## Interface
Parameters:
- `NR`, 10, number of cipher rounds; fixed for AES-128.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; samples `key_in`, loads it as round key 0 and sets round to 0.
- `key_in`  in  128  cipher key; byte i is at [8i+7:8i]; word j is bytes 4j..4j+3.
- `in_valid`  in  1  `in_state` is valid.
- `in_ready`  out  1  stage accepts a beat this cycle.
- `in_state`  in  128  state from `mixcolumns`; byte order is the same as `key_in`.
- `mc_bypass`  out  1  high while the current round is NR; drives the `mixcolumns` bypass.
- `out_valid`  out  1  `out_state` holds a result.
- `out_ready`  in  1  downstream consumes the result.
- `out_state`  out  128  in_state XOR round key.
- `out_round`  out  4  round index (0..NR) of the held result.
- `out_last`  out  1  the held result is round NR (ciphertext).
- `busy`  out  1  the FSM is in ACTIVE.

## Operation
- FSM states:
  - IDLE: `in_ready`=0.
  - `start` moves the FSM to ACTIVE with rk=`key_in` and round=0.
  - ACTIVE: a beat is accepted when `in_valid && in_ready`.
  - On the accept that carries round NR, the FSM returns to IDLE.
- `in_ready` = ACTIVE && !start && (!out_valid || out_ready).
- On each accept, on the same edge:
  - out_state <= in_state ^ rk; out_round <= round; out_last <= (round==NR); out_valid <= 1.
  - rk <= next_key(rk, RCON[round+1]); round <= round+1.
  - No key advance happens when round==NR.
- Round-0 beat: the upstream stages supply the plaintext unchanged, giving the initial AddRoundKey.
- next_key(w0..w3, rc):
  - t = SubWord(RotWord(w3)) ^ {24'h0, rc}.
  - RotWord moves byte1 to byte0, byte2 to byte1, byte3 to byte2 and byte0 to byte3.
  - rc is XORed into byte 0 (bits [7:0] of the word).
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- `mc_bypass` = ACTIVE && round==NR.
- `out_valid` clears when out_ready && no new accept.
- Back-pressure: while out_valid && !out_ready, `out_state`, `out_round` and `out_last` stay stable and `in_ready`=0.
- Abort/restart: `start` in ACTIVE reloads the key, sets round=0 and clears `out_valid`. A beat offered in that cycle is not accepted; start wins.
- `start` and the final accept in the same cycle: start wins, and the final beat is not accepted.
- Reset mid-operation: all state clears immediately; a held result is discarded.

## Timing
- Reset values: FSM=IDLE, round=0, rk=0, out_state=0, out_round=0, out_valid=0, out_last=0, in_ready=0, mc_bypass=0, busy=0.
- Latency: 1 cycle from accept to out_valid.
- Throughput: one beat per cycle when out_ready is held high.
- `in_ready` is one cycle after `start` at the earliest.
- The round key for beat k is ready on the cycle after beat k-1 is accepted, so there is no bubble.
- `mc_bypass` is combinational from registered state. It is valid in the same cycle the NR beat is offered.
- A full sequence is NR+1 accepts. busy falls on the edge that accepts round NR.

## Structure
- Shared package `aes_pkg`:
  - NR, the RCON table, byte/word/state typedefs.
  - FSM state encoding (IDLE, ACTIVE).
- Sub-module `aes_sbox`: combinational byte S-box, instantiated 4× for SubWord.
  - Reused later by the SubBytes stage.
- Key expansion is a function in `aes_pkg`, or inline logic.

## Test plan
- FIPS-197 key schedule, byte 0 first: load key 2b7e151628aed2a6abf7158809cf4f3c and feed an all-zero state for 11 beats.
  - out_state for round 1 = a0fafe1788542cb123a339392a6c7605.
  - out_state for round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; out_last=1 only on that beat.
- Round 0 AddRoundKey: same key, in_state 3243f6a8885a308d313198a2e0370734 → out_state 193de3bea0f4e22b9ac68d2ae9f84808, out_round=0.
- Full loop with `mixcolumns` and a reference SubBytes/ShiftRows model:
  - plaintext 3243f6a8885a308d313198a2e0370734 → final out_state 3925841d02dc09fbdc118597196a0b32.
  - mc_bypass high only during the round-10 beat.
- Back-pressure: hold out_ready=0 for 5 cycles at round 4 → out_state and out_round stable, in_ready=0, round key unchanged; the sequence then completes correctly.
- Restart: assert start at round 6 with a new key → out_valid=0 next cycle. The next accepted beat has out_round=0 and uses the new key.
- Asynchronous reset mid-sequence: all outputs are 0 immediately; after rst_n releases, no accept happens without start.
